// File: rtl/fifo_level_if.sv
// Handshake bundle between a producer/consumer pair and fifo_level.
// The master drives the requests; the slave (the FIFO) returns data and level flags.
interface fifo_level_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO using all DEPTH entries (any DEPTH >= 2), with
// occupancy count, almost flags, sticky error flags and synchronous flush.
module fifo_level #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_level_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty_w, full_w, rd_acc, wr_acc;

    // Non-power-of-two depths need an explicit wrap rather than binary rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign rd_acc  = bus.rd_en & ~empty_w;
    assign wr_acc  = bus.wr_en & (~full_w | rd_acc);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = ptr_inc(wptr_q);
            if (rd_acc) rptr_d = ptr_inc(rptr_q);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.wr_en && !wr_acc) overflow_d  = 1'b1;
            if (bus.rd_en && !rd_acc) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately outside the reset domain; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (wr_acc && !bus.clr) mem_q[wptr_q] <= bus.din;
    end

    assign bus.dout         = mem_q[rptr_q];
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_level.sv
// Randomised plus directed bench for fifo_level against a queue-based reference model.
module tb_fifo_level;
    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int AFL   = 3;
    localparam int AEL   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_level_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fifo_level #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests  = 0;
    int errors = 0;

    // Reference model: a queue of words plus the two sticky bits.
    logic [WIDTH-1:0] mq[$];
    bit m_ovf = 0, m_unf = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.clr) begin
                mq.delete();
                m_ovf = 0;
                m_unf = 0;
            end else begin
                bit ra, wa;
                ra = bus.rd_en && (mq.size() > 0);
                wa = bus.wr_en && ((mq.size() < DEPTH) || ra);
                if (bus.wr_en && !wa) m_ovf = 1;
                if (bus.rd_en && !ra) m_unf = 1;
                if (ra) void'(mq.pop_front());
                if (wa) mq.push_back(bus.din);
            end
        end
    end

    always @(negedge clk) begin
        int n;
        n = mq.size();
        check("count",        bus.count,        n);
        check("empty",        bus.empty,        (n == 0));
        check("full",         bus.full,         (n == DEPTH));
        check("almost_empty", bus.almost_empty, (n <= AEL));
        check("almost_full",  bus.almost_full,  (n >= AFL));
        check("overflow",     bus.overflow,     m_ovf);
        check("underflow",    bus.underflow,    m_unf);
        if (n > 0) check("dout", bus.dout, mq[0]);
    end

    task automatic cyc(input bit wr, input bit rd, input bit cl, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.clr   = cl;
        bus.din   = d;
        $display("[TB] t=%0t wr=%0b rd=%0b clr=%0b din=%02h count=%0d", $time, wr, rd, cl, d, bus.count);
    endtask

    task automatic settle();
        cyc(0, 0, 0, '0);
        #1;
    endtask

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0; bus.din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("lit_reset_count", bus.count, 0);
        check("lit_reset_empty", bus.empty, 1);
        check("lit_reset_ovf",   bus.overflow, 0);

        // Fill 0x11..0x55
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, 0, WIDTH'(i * 8'h11));
        settle();
        check("lit_fill_count", bus.count, 5);
        check("lit_fill_full",  bus.full, 1);
        check("lit_fill_af",    bus.almost_full, 1);
        check("lit_fill_dout",  bus.dout, 8'h11);

        // Pass-through while full
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, WIDTH'(8'hA0 + i));
        settle();
        check("lit_pass_count", bus.count, 5);
        check("lit_pass_ovf",   bus.overflow, 0);
        check("lit_pass_dout",  bus.dout, 8'h44);

        // Overflow, then drain, then underflow
        cyc(1, 0, 0, 8'hEE);
        settle();
        check("lit_ovf_flag",  bus.overflow, 1);
        check("lit_ovf_count", bus.count, 5);
        check("lit_ovf_dout",  bus.dout, 8'h44);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        settle();
        check("lit_unf_flag",  bus.underflow, 1);
        check("lit_unf_empty", bus.empty, 1);

        // Flush with a concurrent write
        cyc(1, 0, 1, 8'h99);
        settle();
        check("lit_clr_count", bus.count, 0);
        check("lit_clr_ovf",   bus.overflow, 0);
        check("lit_clr_unf",   bus.underflow, 0);

        // Empty with simultaneous write and read: write only
        cyc(1, 1, 0, 8'h7E);
        settle();
        check("lit_ewr_count", bus.count, 1);
        check("lit_ewr_dout",  bus.dout, 8'h7E);
        check("lit_ewr_unf",   bus.underflow, 1);
        cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);

        // Randomised traffic with phases biased toward full and toward empty
        for (int i = 0; i < 2000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 75 : 25;
            cyc($urandom_range(99) < wp, $urandom_range(99) >= wp,
                $urandom_range(63) == 0, WIDTH'($urandom));
        end
        cyc(0, 0, 1, '0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, WIDTH'(8'hC0 + i));
        settle();
        check("lit_pre_rst_count", bus.count, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0;
        #1;
        check("lit_async_count", bus.count, 0);
        check("lit_async_empty", bus.empty, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'h5A);
        settle();
        check("lit_post_rst_dout",  bus.dout, 8'h5A);
        check("lit_post_rst_count", bus.count, 1);
        cyc(0, 1, 0, '0);
        settle();
        check("lit_post_rst_empty", bus.empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
